run_sequencer: RTL
==================

# run_sequencer

Host-side run controller for the processor core: the initiator on the core's `req`/`done` handshake. On a start pulse it preloads the core's data memory from an input stream and pulses `req`. It then waits for `done`, counting run cycles with a timeout, and streams a block of result words back out of data memory. It sits between the bench or host harness and the core's `req`/`done` pins and the data-memory host port.

## Interface
- `AW`, 8: data-memory address width
- `DW`, 8: data word width
- `LOAD_BASE`, 0: first data-memory address written in preload
- `LOAD_LEN`, 64: words preloaded (0 = skip preload)
- `RD_BASE`, 64: first address read back
- `RD_LEN`, 32: words read back (0 = skip readback)
- `CW`, 16: cycle-counter width
- `TIMEOUT`, 4095: max RUN cycles before abort
---
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle start pulse
- `in_data`  in  DW  preload word
- `in_valid`  in  1  preload word valid
- `in_ready`  out  1  preload word accepted when `in_valid & in_ready`
- `mem_wr_en`  out  1  data-memory write strobe
- `mem_addr`  out  AW  data-memory address
- `mem_wr_dat`  out  DW  data-memory write data
- `mem_rd_dat`  in  DW  data-memory read data (combinational read of `mem_addr`)
- `req`  out  1  run request to core
- `done`  in  1  core done level
- `out_data`  out  DW  result word
- `out_valid`  out  1  result word valid
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`
- `busy`  out  1  high in any state but IDLE/FIN
- `finished`  out  1  high in FIN
- `timeout_err`  out  1  sticky; set on RUN abort
- `cycle_cnt`  out  CW  RUN cycles of last run, saturating

## Operation
- States: IDLE, LOAD, REQ, RUN, READ, FIN. A counter `idx` tracks the current word.
- IDLE: on `start`, clear `idx`, `cycle_cnt` and `timeout_err`. Go to LOAD, or to REQ if `LOAD_LEN==0`.
- LOAD:
  - `in_ready=1`; `mem_addr=LOAD_BASE+idx`; `mem_wr_dat=in_data`; `mem_wr_en=in_valid`.
  - Each accepted word increments `idx`. On the accept with `idx==LOAD_LEN-1`, go to REQ.
  - `in_valid` low stalls; no write occurs.
- REQ: `req=1` for exactly one cycle. Clear the `armed` flag and go to RUN.
- RUN:
  - `cycle_cnt` increments each cycle and saturates at all-ones.
  - `armed` sets on the first cycle `done==0` is sampled. A stale high `done` from a previous run is ignored.
  - `done==1` while `armed`: go to READ, or FIN if `RD_LEN==0`. Clear `idx`.
  - `cycle_cnt==TIMEOUT` without completion: set `timeout_err` and go to FIN. Readback is skipped.
- READ:
  - `mem_addr=RD_BASE+idx`; `out_data=mem_rd_dat`; `out_valid=1`.
  - Each accept increments `idx`. On the accept with `idx==RD_LEN-1`, go to FIN.
  - `out_ready` low holds `out_data` and the address stable.
- FIN: `finished=1`; `start` begins a new run as in IDLE.
- `start` in LOAD/REQ/RUN/READ is ignored.
- Address arithmetic is modulo 2^AW; base+idx wraps silently.
- `in_ready`, `mem_wr_en` and `out_valid` are 0 outside their states. `mem_addr` is 0 when no state drives it.

## Timing
- Reset: state IDLE, `idx=0`, `req=0`, `in_ready=0`, `mem_wr_en=0`, `mem_addr=0`, `mem_wr_dat=0`, `out_valid=0`, `out_data=0`, `busy=0`, `finished=0`, `timeout_err=0`, `cycle_cnt=0`.
- Reset mid-operation aborts immediately: `req` and `mem_wr_en` drop the next edge, and no further memory writes occur.
- `start` at edge t puts the block in LOAD at t+1. It can accept one word per cycle, so preload takes at least `LOAD_LEN` cycles.
- `req` is high for the single cycle after the last preload accept. RUN begins the next cycle, and its first cycle counts as `cycle_cnt=1`.
- `done` is sampled every RUN cycle, so exit occurs at the first edge where `armed & done`. `armed` sets at the edge where `done==0` is seen; `done` high on that same edge does not count.
- Readback runs at one word per cycle with `out_ready` held high. The last accept moves the block to FIN at the next edge.
- All outputs are registered state decodes, except that `mem_wr_en`, `mem_wr_dat` and `out_data` follow their inputs combinationally within the state.

## Test plan
- Nominal run with `LOAD_LEN=4`, `RD_LEN=2`: feed 0x11,0x22,0x33,0x44. The core model drops `done` one cycle after `req` and raises it 10 cycles later. Required: writes to addresses 0..3, a single `req` pulse, `cycle_cnt=11`, `out_data` = mem[64],mem[65], then `finished=1` and `timeout_err=0`.
- Backpressure: toggle `in_valid` and `out_ready` every other cycle. Required: no duplicate or skipped writes or reads, and `mem_addr` and `out_data` stay stable while stalled.
- Stale done: hold `done=1` through REQ, drop it for one cycle, then raise it. Required: RUN does not exit until after the low cycle.
- Timeout with `TIMEOUT=20` and `done` stuck at 0. Required: FIN at `cycle_cnt=20`, `timeout_err=1`, `out_valid` never asserted.
- Reset in RUN and in LOAD: required all-zero outputs on the next cycle. A new `start` then completes a nominal run.
- `start` pulsed during READ is ignored. With `LOAD_LEN=0`, `req` asserts the cycle after `start`.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: host-side run controller for the processor core.
// On start it preloads LOAD_LEN words from the input stream into data memory,
// pulses req to the core, waits for done while counting run cycles (with a
// timeout), then streams RD_LEN result words from data memory to the output.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle start pulse (honoured in IDLE/FIN only)
//   in_data/valid/ready   preload stream (ready/valid)
//   mem_wr_en/addr/wr_dat data-memory host port, write side
//   mem_rd_dat            data-memory read data (combinational on mem_addr)
//   req, done             core handshake: req pulse out, done level in
//   out_data/valid/ready  readback stream (ready/valid)
//   busy, finished        status: busy outside IDLE/FIN, finished in FIN
//   timeout_err           sticky; set when RUN is aborted by the timeout
//   cycle_cnt             RUN cycles of the last run, saturating
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting preload words into memory
// REQ   | one-cycle run request to the core
// RUN   | waiting for done (armed by a low done), counting cycles
// READ  | streaming result words out of memory
// FIN   | run complete; start begins a new run
module run_sequencer #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RD_BASE   = 64,
  parameter int RD_LEN    = 32,
  parameter int CW        = 16,
  parameter int TIMEOUT   = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_dat,
  input  logic [DW-1:0] mem_rd_dat,
  output logic          req,
  input  logic          done,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout_err,
  output logic [CW-1:0] cycle_cnt
);

  localparam int MAXLEN = (LOAD_LEN > RD_LEN) ? LOAD_LEN : RD_LEN;
  localparam int IW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_RUN, S_READ, S_FIN
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          armed, armed_nx;
  logic [CW-1:0] cnt_nx;
  logic          terr_nx;
  logic [CW-1:0] cnt_inc;

  // Saturating increment: the counter sticks at all-ones.
  assign cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      armed       <= 1'b0;
      cycle_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      armed       <= armed_nx;
      cycle_cnt   <= cnt_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    armed_nx   = armed;
    cnt_nx     = cycle_cnt;
    terr_nx    = timeout_err;
    in_ready   = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wr_dat = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    req        = 1'b0;
    case (state)
      S_IDLE, S_FIN: begin
        if (start) begin
          idx_nx   = '0;
          cnt_nx   = '0;
          terr_nx  = 1'b0;
          state_nx = (LOAD_LEN == 0) ? S_REQ : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready   = 1'b1;
        mem_addr   = AW'(LOAD_BASE) + AW'(idx);
        mem_wr_dat = in_data;
        mem_wr_en  = in_valid;
        if (in_valid) begin
          idx_nx = idx + 1'b1;
          if (idx == IW'(LOAD_LEN - 1)) state_nx = S_REQ;
        end
      end
      S_REQ: begin
        req      = 1'b1;
        armed_nx = 1'b0;
        state_nx = S_RUN;
      end
      S_RUN: begin
        cnt_nx = cnt_inc;
        // A done still high from the previous run is ignored until the
        // core has been seen to drop it at least once.
        if (!done) armed_nx = 1'b1;
        if (armed && done) begin
          idx_nx   = '0;
          state_nx = (RD_LEN == 0) ? S_FIN : S_READ;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          terr_nx  = 1'b1;
          state_nx = S_FIN;
        end
      end
      S_READ: begin
        mem_addr  = AW'(RD_BASE) + AW'(idx);
        out_data  = mem_rd_dat;
        out_valid = 1'b1;
        if (out_ready) begin
          idx_nx = idx + 1'b1;
          if (idx == IW'(RD_LEN - 1)) state_nx = S_FIN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE) && (state != S_FIN);
  assign finished = (state == S_FIN);

endmodule
